// File: rtl/mw_writeback_stage.sv
// MEM/WB pipeline latch, writeback decoder and register-file write-port arbiter.
// The pipeline slot always wins the port; late multdiv results wait in a small FIFO.
module mw_writeback_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LINK_REG       = 31,
  parameter int STATUS_REG     = 30,
  parameter int MD_DEPTH       = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_mw_en,
  input  logic                      i_mw_flush,
  input  logic                      i_in_valid,
  input  logic [31:0]               i_in_insn,
  input  logic [DATA_WIDTH-1:0]     i_in_o,
  input  logic [DATA_WIDTH-1:0]     i_in_d,
  input  logic                      i_in_exc,
  input  logic                      i_md_valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_md_reg,
  input  logic [DATA_WIDTH-1:0]     i_md_data,
  output logic                      o_md_ready,
  output logic                      o_md_pending,
  output logic                      o_wb_we,
  output logic [REG_ADDR_WIDTH-1:0] o_wb_reg,
  output logic [DATA_WIDTH-1:0]     o_wb_data,
  output logic                      o_byp_valid,
  output logic [REG_ADDR_WIDTH-1:0] o_byp_reg,
  output logic [DATA_WIDTH-1:0]     o_byp_data
);

  localparam int PW = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
  localparam int CW = $clog2(MD_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(MD_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(MD_DEPTH);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  logic                      r_valid;
  logic [31:0]               r_insn;
  logic [DATA_WIDTH-1:0]     r_o;
  logic [DATA_WIDTH-1:0]     r_d;
  logic                      r_exc;
  logic                      r_done;

  logic [REG_ADDR_WIDTH-1:0] r_q_reg  [MD_DEPTH];
  logic [DATA_WIDTH-1:0]     r_q_data [MD_DEPTH];
  logic [PW-1:0]             r_head;
  logic [PW-1:0]             r_tail;
  logic [CW-1:0]             r_count;

  logic                      w_dec_we;
  logic [REG_ADDR_WIDTH-1:0] w_dec_reg;
  logic [DATA_WIDTH-1:0]     w_dec_data;
  logic                      w_slot_wr;
  logic                      w_push;
  logic                      w_pop;
  logic [4:0]                w_opcode;
  logic [REG_ADDR_WIDTH-1:0] w_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign w_opcode = r_insn[31:27];
  assign w_rd     = REG_ADDR_WIDTH'(r_insn[26:22]);

  always_comb begin
    w_dec_we   = 1'b0;
    w_dec_reg  = '0;
    w_dec_data = '0;
    if (r_exc) begin
      w_dec_we   = 1'b1;
      w_dec_reg  = REG_ADDR_WIDTH'(STATUS_REG);
      w_dec_data = r_o;
    end else begin
      case (w_opcode)
        OP_LW: begin
          w_dec_we   = 1'b1;
          w_dec_reg  = w_rd;
          w_dec_data = r_d;
        end
        OP_JAL: begin
          w_dec_we   = 1'b1;
          w_dec_reg  = REG_ADDR_WIDTH'(LINK_REG);
          w_dec_data = r_o;
        end
        OP_SETX: begin
          w_dec_we   = 1'b1;
          w_dec_reg  = REG_ADDR_WIDTH'(STATUS_REG);
          w_dec_data = r_o;
        end
        OP_RTYPE, OP_ADDI: begin
          w_dec_we   = 1'b1;
          w_dec_reg  = w_rd;
          w_dec_data = r_o;
        end
        default: ;
      endcase
    end
  end

  // r0 writes never take the port, so the queue can drain in that cycle
  assign w_slot_wr = r_valid & ~r_done & w_dec_we & (w_dec_reg != '0);

  assign w_pop  = ~w_slot_wr & (r_count != '0);
  assign w_push = i_md_valid & o_md_ready & (i_md_reg != '0);

  assign o_md_ready   = ~i_reset & (r_count < DEPTH_C);
  assign o_md_pending = (r_count != '0);

  always_comb begin
    o_wb_we   = 1'b0;
    o_wb_reg  = '0;
    o_wb_data = '0;
    if (w_slot_wr) begin
      o_wb_we   = 1'b1;
      o_wb_reg  = w_dec_reg;
      o_wb_data = w_dec_data;
    end else if (r_count != '0) begin
      o_wb_we   = 1'b1;
      o_wb_reg  = r_q_reg[r_head];
      o_wb_data = r_q_data[r_head];
    end
  end

  assign o_byp_valid = o_wb_we;
  assign o_byp_reg   = o_wb_reg;
  assign o_byp_data  = o_wb_data;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_insn  <= '0;
      r_o     <= '0;
      r_d     <= '0;
      r_exc   <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_mw_flush) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_mw_en) begin
      r_valid <= i_in_valid;
      r_insn  <= i_in_insn;
      r_o     <= i_in_o;
      r_d     <= i_in_d;
      r_exc   <= i_in_exc;
      r_done  <= 1'b0;
    end else if (w_slot_wr) begin
      r_done  <= 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < MD_DEPTH; i++) begin
        r_q_reg[i]  <= '0;
        r_q_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_q_reg[r_tail]  <= i_md_reg;
        r_q_data[r_tail] <= i_md_data;
        r_tail           <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mw_writeback_stage.sv
// Self-checking bench for mw_writeback_stage: decode table, hand-written corner
// sequences and a randomized run, all compared against a queue-based reference model.
module tb_mw_writeback_stage;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        mw_en;
  logic        mw_flush;
  logic        in_valid;
  logic [31:0] in_insn;
  logic [31:0] in_o;
  logic [31:0] in_d;
  logic        in_exc;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        md_pending;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        byp_valid;
  logic [4:0]  byp_reg;
  logic [31:0] byp_data;

  int n_pass  = 0;
  int n_total = 0;

  mw_writeback_stage #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .LINK_REG(31), .STATUS_REG(30), .MD_DEPTH(DEPTH)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_mw_en(mw_en), .i_mw_flush(mw_flush),
    .i_in_valid(in_valid), .i_in_insn(in_insn), .i_in_o(in_o), .i_in_d(in_d),
    .i_in_exc(in_exc), .i_md_valid(md_valid), .i_md_reg(md_reg), .i_md_data(md_data),
    .o_md_ready(md_ready), .o_md_pending(md_pending), .o_wb_we(wb_we),
    .o_wb_reg(wb_reg), .o_wb_data(wb_data), .o_byp_valid(byp_valid),
    .o_byp_reg(byp_reg), .o_byp_data(byp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the latched instruction as plain fields plus a FIFO of results
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } md_t;

  md_t         mq[$];
  logic        m_valid, m_exc, m_done;
  logic [31:0] m_insn, m_o, m_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic void ref_decode(input logic [31:0] insn, input logic [31:0] o,
                                     input logic [31:0] d, input logic exc,
                                     output logic we, output logic [4:0] rg,
                                     output logic [31:0] dt);
    int op;
    int rd;
    op = int'(insn[31:27]);
    rd = int'(insn[26:22]);
    we = 1'b0; rg = 5'd0; dt = 32'd0;
    if (exc) begin
      we = 1'b1; rg = 5'd30; dt = o;
    end else begin
      case (op)
        8:       begin we = 1'b1; rg = 5'(rd); dt = d; end
        3:       begin we = 1'b1; rg = 5'd31;  dt = o; end
        21:      begin we = 1'b1; rg = 5'd30;  dt = o; end
        0, 5:    begin we = 1'b1; rg = 5'(rd); dt = o; end
        default: ;
      endcase
    end
    if (rg == 5'd0) we = 1'b0;
  endfunction

  function automatic logic model_slot_writes();
    logic we; logic [4:0] rg; logic [31:0] dt;
    ref_decode(m_insn, m_o, m_d, m_exc, we, rg, dt);
    return m_valid && !m_done && we;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_valid = 0; m_exc = 0; m_done = 0;
    m_insn = 0; m_o = 0; m_d = 0;
  endtask

  task automatic model_check();
    logic we; logic [4:0] rg; logic [31:0] dt;
    logic ewe; logic [4:0] erg; logic [31:0] edt;
    ref_decode(m_insn, m_o, m_d, m_exc, we, rg, dt);
    ewe = 0; erg = 0; edt = 0;
    if (model_slot_writes()) begin
      ewe = 1; erg = rg; edt = dt;
    end else if (mq.size() > 0) begin
      ewe = 1; erg = mq[0].r; edt = mq[0].d;
    end
    chk("model_wb_we", 32'(wb_we), 32'(ewe));
    chk("model_wb_reg", 32'(wb_reg), 32'(erg));
    chk("model_wb_data", wb_data, edt);
    chk("model_md_ready", 32'(md_ready), 32'(mq.size() < DEPTH));
    chk("model_md_pending", 32'(md_pending), 32'(mq.size() > 0));
    chk("model_byp", {byp_valid, byp_reg, byp_data[25:0]}, {ewe, erg, edt[25:0]});
  endtask

  task automatic model_update();
    logic slot;
    logic ready;
    slot  = model_slot_writes();
    ready = (mq.size() < DEPTH);
    if (!slot && mq.size() > 0) void'(mq.pop_front());
    if (md_valid && ready && md_reg != 5'd0) mq.push_back('{r: md_reg, d: md_data});
    if (mw_flush) begin
      m_valid = 0; m_done = 0;
    end else if (mw_en) begin
      m_valid = in_valid; m_insn = in_insn; m_o = in_o; m_d = in_d; m_exc = in_exc; m_done = 0;
    end else if (slot) begin
      m_done = 1;
    end
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mw_en = 0; mw_flush = 0; in_valid = 0; in_insn = 0; in_o = 0; in_d = 0;
    in_exc = 0; md_valid = 0; md_reg = 0; md_data = 0;
  endtask

  task automatic latch(input logic [31:0] insn, input logic [31:0] o,
                       input logic [31:0] d, input logic exc);
    mw_en = 1; in_valid = 1; in_insn = insn; in_o = o; in_d = d; in_exc = exc;
  endtask

  task automatic offer(input logic [4:0] r, input logic [31:0] d);
    md_valid = 1; md_reg = r; md_data = d;
  endtask

  task automatic expect_wb(input string name, input logic we, input logic [4:0] r,
                           input logic [31:0] d);
    chk({name, "_we"}, 32'(wb_we), 32'(we));
    chk({name, "_reg"}, 32'(wb_reg), 32'(r));
    chk({name, "_data"}, wb_data, d);
  endtask

  typedef struct {
    string       name;
    logic [31:0] insn;
    logic [31:0] o;
    logic [31:0] d;
    logic        exc;
    logic        we;
    logic [4:0]  rg;
    logic [31:0] dt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"lw",       32'h40C0_0000, 32'h5,    32'hDEAD_0001, 1'b0, 1'b1, 5'd3,  32'hDEAD_0001};
    vecs[1] = '{"jal",      32'h1800_0000, 32'h42,   32'h9,         1'b0, 1'b1, 5'd31, 32'h42};
    vecs[2] = '{"setx",     32'hA800_0000, 32'h7,    32'h0,         1'b0, 1'b1, 5'd30, 32'h7};
    vecs[3] = '{"exc_add",  32'h0100_0000, 32'h1,    32'h3,         1'b1, 1'b1, 5'd30, 32'h1};
    vecs[4] = '{"branch",   32'h1000_0000, 32'h55,   32'h66,        1'b0, 1'b0, 5'd0,  32'h0};
    vecs[5] = '{"addi",     32'h29C0_0000, 32'h123,  32'h0,         1'b0, 1'b1, 5'd7,  32'h123};
    vecs[6] = '{"rtype_r0", 32'h0000_0000, 32'h99,   32'h0,         1'b0, 1'b0, 5'd0,  32'h0};
    vecs[7] = '{"lw_r0",    32'h4000_0000, 32'h1,    32'h2,         1'b0, 1'b0, 5'd0,  32'h0};

    idle_inputs();
    model_reset();
    rst = 1;
    #2;
    expect_wb("reset", 1'b0, 5'd0, 32'd0);
    chk("reset_md_ready", 32'(md_ready), 32'd0);
    chk("reset_md_pending", 32'(md_pending), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    settle();
    chk("post_reset_ready", 32'(md_ready), 32'd1);

    // Decode table: latch each instruction, check the following cycle
    for (int i = 0; i < 8; i++) begin
      latch(vecs[i].insn, vecs[i].o, vecs[i].d, vecs[i].exc);
      settle();
      advance();
      idle_inputs();
      settle();
      expect_wb(vecs[i].name, vecs[i].we, vecs[i].rg, vecs[i].dt);
      advance();
    end

    // r0 R-type leaves the port free for a queued result the same cycle
    latch(32'h0000_0000, 32'h5, 32'h0, 1'b0);
    offer(5'd9, 32'h77);
    settle(); advance(); idle_inputs();
    settle(); expect_wb("r0_md", 1'b1, 5'd9, 32'h77);
    advance();
    settle(); expect_wb("r0_md_after", 1'b0, 5'd0, 32'd0);
    advance();

    // Slot beats queue; queued result follows one cycle later
    latch(32'h0180_0000, 32'hAA, 32'h0, 1'b0);
    offer(5'd5, 32'h11);
    settle(); advance(); idle_inputs();
    settle(); expect_wb("conf_slot", 1'b1, 5'd6, 32'hAA);
    chk("conf_pend1", 32'(md_pending), 32'd1);
    advance();
    settle(); expect_wb("conf_md", 1'b1, 5'd5, 32'h11);
    chk("conf_pend2", 32'(md_pending), 32'd1);
    advance();
    settle(); chk("conf_pend3", 32'(md_pending), 32'd0);
    advance();

    // Fill the queue behind back-to-back slot writes
    latch(32'h2840_0000, 32'h1, 32'h0, 1'b0);
    offer(5'd10, 32'hA0);
    settle(); advance();
    latch(32'h2880_0000, 32'h2, 32'h0, 1'b0);
    offer(5'd11, 32'hB0);
    settle(); expect_wb("full_s1", 1'b1, 5'd1, 32'h1);
    chk("full_ready1", 32'(md_ready), 32'd1);
    advance();
    latch(32'h28C0_0000, 32'h3, 32'h0, 1'b0);
    offer(5'd12, 32'hC0);
    settle(); expect_wb("full_s2", 1'b1, 5'd2, 32'h2);
    chk("full_ready0", 32'(md_ready), 32'd0);
    advance(); idle_inputs();
    settle(); expect_wb("full_s3", 1'b1, 5'd3, 32'h3);
    chk("full_ready0b", 32'(md_ready), 32'd0);
    advance();
    settle(); expect_wb("full_q1", 1'b1, 5'd10, 32'hA0);
    advance();
    settle(); expect_wb("full_q2", 1'b1, 5'd11, 32'hB0);
    chk("full_ready_after_pop", 32'(md_ready), 32'd1);
    advance();
    settle(); expect_wb("full_empty", 1'b0, 5'd0, 32'd0);
    chk("full_pending0", 32'(md_pending), 32'd0);
    advance();

    // Stalled slot writes once, then the queue drains; flush beats mw_en
    latch(32'h2880_0000, 32'h22, 32'h0, 1'b0);
    offer(5'd13, 32'hD0);
    settle(); advance(); idle_inputs();
    settle(); expect_wb("stall_c1", 1'b1, 5'd2, 32'h22);
    advance();
    settle(); expect_wb("stall_c2", 1'b1, 5'd13, 32'hD0);
    advance();
    settle(); expect_wb("stall_c3", 1'b0, 5'd0, 32'd0);
    advance();
    latch(32'h2900_0000, 32'h44, 32'h0, 1'b0);
    mw_flush = 1;
    settle(); advance(); idle_inputs();
    settle(); expect_wb("flush", 1'b0, 5'd0, 32'd0);
    advance();

    // Async reset with two queued entries and a live slot
    latch(32'h2840_0000, 32'h1, 32'h0, 1'b0);
    offer(5'd14, 32'hE0);
    settle(); advance();
    latch(32'h28C0_0000, 32'h3, 32'h0, 1'b0);
    offer(5'd15, 32'hF0);
    settle(); advance(); idle_inputs();
    settle();
    chk("prerst_pending", 32'(md_pending), 32'd1);
    #2 rst = 1;
    #1;
    expect_wb("rst_async", 1'b0, 5'd0, 32'd0);
    chk("rst_ready", 32'(md_ready), 32'd0);
    chk("rst_pending", 32'(md_pending), 32'd0);
    offer(5'd16, 32'h1234);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    idle_inputs();
    settle();
    chk("rel_ready", 32'(md_ready), 32'd1);
    expect_wb("rel_nostale", 1'b0, 5'd0, 32'd0);
    advance();
    settle(); expect_wb("rel_nostale2", 1'b0, 5'd0, 32'd0);
    advance();

    // Randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      int ops[7] = '{0, 5, 8, 3, 21, 2, 7};
      mw_en    = ($urandom_range(0, 1) == 1);
      mw_flush = ($urandom_range(0, 9) == 0);
      in_valid = ($urandom_range(0, 5) != 0);
      in_insn  = {5'(ops[$urandom_range(0, 6)]), 5'($urandom_range(0, 31)), 22'($urandom)};
      in_o     = $urandom;
      in_d     = $urandom;
      in_exc   = ($urandom_range(0, 9) == 0);
      md_valid = ($urandom_range(0, 4) < 2);
      md_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      md_data  = $urandom;
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mw_writeback_stage.md
Name: mw_writeback_stage

Overview:
- Registered MEM/WB pipeline latch plus writeback decoder/arbiter for the 5-stage core.
- Selects writeback data and target register for the latched instruction: lw, jal, setx, exception, R-type and addi.
- Owns the single register-file write port. Arbitrates it between the pipeline slot and a DEPTH-entry queue of late results from the multdiv unit.
- Also drives the bypass/forwarding outputs.

Parameters:
DATA_WIDTH, 32, width of o/d/multdiv data and write data
REG_ADDR_WIDTH, 5, register-file address width
LINK_REG, 31, jal target register
STATUS_REG, 30, setx/exception target register (rstatus)
MD_DEPTH, 2, multdiv result queue entries (>=1)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
mw_en  in  1  latch new XM-stage values this edge; 0 = hold
mw_flush  in  1  load bubble this edge (wins over mw_en)
in_valid  in  1  XM slot holds a real instruction
in_insn  in  32  instruction; opcode [31:27], rd [26:22]
in_o  in  DATA_WIDTH  ALU result / PC+1 / T / exception code
in_d  in  DATA_WIDTH  memory load data
in_exc  in  1  XM instruction raised exception
md_valid  in  1  multdiv result offered
md_reg  in  REG_ADDR_WIDTH  multdiv destination
md_data  in  DATA_WIDTH  multdiv result
md_ready  out  1  queue can accept (count < MD_DEPTH)
md_pending  out  1  queue non-empty
wb_we  out  1  register-file write enable
wb_reg  out  REG_ADDR_WIDTH  write address
wb_data  out  DATA_WIDTH  write data
byp_valid  out  1  equals wb_we (forwarding qualifier)
byp_reg  out  REG_ADDR_WIDTH  equals wb_reg
byp_data  out  DATA_WIDTH  equals wb_data

Behaviour:
- Reset (async):
  - Latch valid=0, insn/o/d/exc=0, done=0.
  - Queue count, head and tail=0.
  - Outputs while reset is high: wb_we=0, wb_reg=0, wb_data=0, md_pending=0, md_ready=0.
  - md_ready=1 from the first cycle after reset deasserts.
- Latch update at each edge:
  - mw_flush=1: valid=0, done=0.
  - Else mw_en=1: load all in_* fields, done=0.
  - Else hold all fields. done<=1 if the slot wrote this cycle.
- Slot decode from latched fields (opcode = insn[31:27]):
  - exc=1: target=STATUS_REG, data=o. Overrides opcode.
  - 01000 lw: target=rd, data=d.
  - 00011 jal: target=LINK_REG, data=o.
  - 10101 setx: target=STATUS_REG, data=o.
  - 00000 R-type and 00101 addi: target=rd, data=o.
  - All other opcodes: no write.
- slot_wr = valid & ~done & decoded-write & (target != 0). Writes to r0 are suppressed and never consume the port.
- A held (stalled) instruction writes exactly once. The port is then free for the queue.
- Port arbitration, combinational from state:
  - slot_wr=1: wb = slot target/data.
  - Else count>0: wb_we=1, wb = queue head. Head pops at the next edge.
  - Else wb_we=0, wb_reg=0, wb_data=0.
  - Pipeline slot always has priority.
- Queue push:
  - md_valid & md_ready pushes {md_reg, md_data} at the edge.
  - Push with md_reg=0 is accepted and discarded (not stored).
- Queue full:
  - md_ready = (count < MD_DEPTH), from registered count.
  - No push when full, even if a pop occurs the same edge.
- Simultaneous push and pop when not full: count unchanged. Pointers wrap modulo MD_DEPTH.
- Queue ordering: FIFO.
- Latency:
  - Multdiv result accepted at edge N is written no earlier than the cycle after edge N.
  - Pipeline slot writes in the cycle after it is latched.
- Ordering hazard between queued and pipeline writes to the same register is upstream's responsibility. Upstream uses md_pending to stall.
- md_valid while reset is high is ignored.

Test Plan:
- Basic decode:
  - Latch lw insn 0x40C00000 (rd=3), d=0xDEAD0001, o=0x5 -> next cycle wb_we=1, wb_reg=3, wb_data=0xDEAD0001.
  - Latch jal opcode 00011, o=0x00000042 -> wb_reg=31, wb_data=0x42.
  - Setx with o=7 -> wb_reg=30, wb_data=7.
  - Exception on add rd=4, o=1 -> wb_reg=30, wb_data=1.
  - Branch opcode 00010 -> wb_we=0.
- R-type with rd=0 -> wb_we=0. Same cycle, queued md entry (reg 9, data 0x77) writes: wb_reg=9, wb_data=0x77.
- Conflict:
  - md push (reg 5, 0x11) at edge N while R-type rd=6 writes at N+1 -> N+1 writes r6, N+2 writes r5 with 0x11.
  - md_pending=1 through N+1, 0 after N+2 edge.
- Queue full (MD_DEPTH=2):
  - Push two entries while consecutive pipeline writes occupy the port -> md_ready=0; third md_valid is not accepted.
  - After the first pop, md_ready=1.
  - Order preserved.
- Stall:
  - mw_en=0 holding addi rd=2, one md entry queued -> cycle 1 writes r2, cycle 2 writes md entry, cycle 3 wb_we=0.
  - Flush then clears the slot.
- Reset mid-operation:
  - Assert reset asynchronously with 2 queued entries and a valid slot -> wb_we=0 and md_ready=0 immediately, md_pending=0.
  - After release, no stale writes occur; md_ready=1.
